uart_program_loader: RTL
========================

// Module: uart_program_loader
// PURPOSE
//  Framed, checksummed loader that sequences UART receive bytes into the core's code RAM.
//  It holds the core in reset until a valid image is resident.
//  Sits between the UART receiver and the code RAM write port.
//  Drives the core/memory-controller hold in place of the ad-hoc byte counter.
//  Frame: SYNC, LEN_LO, LEN_HI, LEN data bytes, CHECKSUM (8-bit sum of data bytes, mod 256).
// PARAMETERS
//  CODE_DEPTH      256         code RAM size in bytes; legal LEN is 1..CODE_DEPTH
//  ADDR_W          8           code RAM address width, $clog2(CODE_DEPTH)
//  SYNC_BYTE       8'hA5       frame start marker
//  TIMEOUT_CYCLES  10_000_000  max clk cycles between bytes inside a frame
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  rx_data     in   8       byte from UART receiver
//  rx_valid    in   1       one-cycle strobe, rx_data valid
//  wr_en       out  1       code RAM write strobe
//  wr_addr     out  ADDR_W  code RAM write address
//  wr_data     out  8       code RAM write data
//  core_hold   out  1       1 = keep core and memory controller in reset
//  load_done   out  1       one-cycle pulse: image accepted, core released
//  load_error  out  1       one-cycle pulse: frame rejected
//  state_dbg   out  3       current FSM state encoding, for LEDs
// BEHAVIOUR
//  - Reset values: wr_en=0, wr_addr=0, wr_data=0, core_hold=1, load_done=0, load_error=0, state=WAIT_SYNC.
//  - A reset mid-frame abandons the frame. Code RAM contents are not restored.
//  - All outputs are registered. A write occurs 1 cycle after the accepting rx_valid.
//  - FSM states:
//    - WAIT_SYNC: non-SYNC bytes are ignored. On SYNC -> LEN_LO.
//    - LEN_LO: store byte -> LEN_HI.
//    - LEN_HI: form LEN = {hi,lo}.
//      - LEN==0 or LEN>CODE_DEPTH -> ERROR.
//      - Otherwise clear count and sum -> DATA.
//    - DATA: each byte is written at wr_addr=count[ADDR_W-1:0] and added to sum (8-bit wrap); count++.
//      When count reaches LEN -> CHECK.
//    - CHECK: on the next byte, byte==sum -> FILL (if LEN<CODE_DEPTH) or DONE (if LEN==CODE_DEPTH).
//      Otherwise -> ERROR.
//    - FILL: writes 8'h00 at addresses LEN..CODE_DEPTH-1, one per cycle, without waiting for rx. Then -> DONE.
//    - DONE: load_done=1 for one cycle, core_hold<=0 -> RUN.
//    - RUN: core runs. Non-SYNC bytes are ignored.
//      On SYNC: core_hold<=1 in the same registered step -> LEN_LO. The core stops before any RAM write.
//    - ERROR: load_error=1 for one cycle; core_hold stays 1 -> WAIT_SYNC.
//  - Timeout: in LEN_LO, LEN_HI, DATA or CHECK, an idle counter resets on every rx_valid.
//    When it reaches TIMEOUT_CYCLES-1 -> ERROR. It is inactive in WAIT_SYNC/RUN/FILL.
//  - A SYNC value inside LEN/DATA/CHECK is treated as ordinary data (no resync).
//  - rx_valid during FILL, DONE or ERROR is dropped.
//  - A count wrap at CODE_DEPTH is impossible because LEN<=CODE_DEPTH. count is ADDR_W+1 bits wide.
//  - wr_en is never asserted outside DATA and FILL. core_hold never deasserts except via DONE.
// STRUCTURE
//  - pisa_loader_pkg: loader_state_e enum (WAIT_SYNC, LEN_LO, LEN_HI, DATA, CHECK, FILL, DONE, ERROR, RUN),
//    with state_dbg = enum value; default SYNC_BYTE constant.
//  - Sub-module rx_idle_timer (clear, enable, expired).
//  - The FSM, count, sum and LEN registers live in the top module.
// TESTING
//  1. Reset, send A5 04 00 11 22 33 44 AA:
//     - writes 11,22,33,44 at addresses 0..3;
//     - 00 fill at 4..255 (252 writes);
//     - load_done pulses once; core_hold 1->0.
//  2. Full image: LEN=256 (A5 00 01), 256 bytes of 01, checksum 00:
//     - no FILL; load_done pulses; wr_addr ends at 255.
//  3. Bad checksum: A5 02 00 10 20 31:
//     - load_error pulses; core_hold stays 1; the next valid frame loads normally.
//  4. Bad LEN (A5 00 00, and A5 01 01):
//     - ERROR right after LEN_HI, no wr_en.
//     - Bytes 55 FF sent before A5 are ignored.
//  5. Timeout: A5 04 00 11, then idle TIMEOUT_CYCLES (set to 100 in the bench):
//     - load_error pulses at cycle 100 after the last byte.
//  6. In RUN, send A5: core_hold=1 on the next cycle.
//     Assert rst mid-DATA: all outputs return to reset values, state=WAIT_SYNC.

Source files
------------

// File: rtl/uart_program_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_program_loader_pkg;

  // Loader FSM states. The encoding doubles as the LED debug code (low 3 bits).
  typedef enum logic [3:0] {
    WAIT_SYNC = 4'd0,
    LEN_LO    = 4'd1,
    LEN_HI    = 4'd2,
    DATA      = 4'd3,
    CHECK     = 4'd4,
    FILL      = 4'd5,
    DONE      = 4'd6,
    ERROR     = 4'd7,
    RUN       = 4'd8
  } loader_state_e;

  // Default frame start marker.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Debug code shown on the LEDs. RUN shares code 0 with WAIT_SYNC; the two
  // are told apart by core_hold (0 only in RUN).
  function automatic logic [2:0] state_code(input loader_state_e s);
    return s[2:0];
  endfunction

endpackage

// File: rtl/uart_program_loader_rx_idle_timer.sv
// Inter-byte idle timer: counts cycles since the last clear while enabled and
// flags expiry once TIMEOUT_CYCLES-1 idle cycles have elapsed.
module rx_idle_timer #(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expired = enable && (count == LAST);

  // Idle counter: cleared on every byte or when inactive, saturates at expiry.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Framed, checksummed UART program loader. Writes an image into code RAM and
// holds the core in reset until a complete, checksum-valid image is resident.
// Frame: SYNC, LEN_LO, LEN_HI, LEN data bytes, CHECKSUM (8-bit sum of data).
//
// Handshake: rx_valid is a single-cycle strobe with no back-pressure; a byte is
// consumed in the cycle rx_valid is high, or dropped if the FSM is in a state
// that does not accept bytes (FILL, DONE, ERROR). wr_en is a single-cycle write
// strobe with wr_addr/wr_data valid in the same cycle; the RAM cannot stall it.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int          CODE_DEPTH     = 256,
  parameter int          ADDR_W         = 8,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int          TIMEOUT_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_error,
  output logic [2:0]        state_dbg
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(CODE_DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(CODE_DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  loader_state_e     state, state_next;
  logic [ADDR_W:0]   count, count_next;
  logic [ADDR_W:0]   len, len_next;
  logic [7:0]        len_lo, len_lo_next;
  logic [7:0]        sum, sum_next;
  logic              wr_en_next;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [7:0]        wr_data_next;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   count_inc;
  logic              active;
  logic              expired;

  assign state_dbg = state_code(state);
  assign len_full  = {rx_data, len_lo};
  assign count_inc = count + ONE_C;
  assign active    = (state == LEN_LO) || (state == LEN_HI) ||
                     (state == DATA)   || (state == CHECK);

  rx_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid || !active),
    .enable (active),
    .expired(expired)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_SYNC;
      count      <= '0;
      len        <= '0;
      len_lo     <= '0;
      sum        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      len        <= len_next;
      len_lo     <= len_lo_next;
      sum        <= sum_next;
      wr_en      <= wr_en_next;
      wr_addr    <= wr_addr_next;
      wr_data    <= wr_data_next;
      // The core runs only while in RUN; leaving RUN re-asserts hold in the
      // same step, so the core is stopped before the first new RAM write.
      core_hold  <= (state_next != RUN);
      load_done  <= (state_next == DONE);
      load_error <= (state_next == ERROR);
    end
  end

  // Next-state and datapath updates; an arriving byte takes priority over timeout.
  always_comb begin
    state_next   = state;
    count_next   = count;
    len_next     = len;
    len_lo_next  = len_lo;
    sum_next     = sum;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr;
    wr_data_next = wr_data;
    case (state)
      WAIT_SYNC: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_lo_next = rx_data;
          state_next  = LEN_HI;
        end else if (expired) begin
          state_next = ERROR;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          if ((len_full == 16'd0) || (len_full > 16'(CODE_DEPTH))) begin
            state_next = ERROR;
          end else begin
            len_next   = len_full[ADDR_W:0];
            count_next = '0;
            sum_next   = '0;
            state_next = DATA;
          end
        end else if (expired) begin
          state_next = ERROR;
        end
      end
      DATA: begin
        if (rx_valid) begin
          wr_en_next   = 1'b1;
          wr_addr_next = count[ADDR_W-1:0];
          wr_data_next = rx_data;
          sum_next     = sum + rx_data;
          count_next   = count_inc;
          if (count_inc == len) state_next = CHECK;
        end else if (expired) begin
          state_next = ERROR;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data != sum)     state_next = ERROR;
          else if (len == DEPTH_C) state_next = DONE;
          else                     state_next = FILL;
        end else if (expired) begin
          state_next = ERROR;
        end
      end
      FILL: begin
        // count still holds LEN here, so zero-fill starts right after the image.
        wr_en_next   = 1'b1;
        wr_addr_next = count[ADDR_W-1:0];
        wr_data_next = 8'h00;
        count_next   = count_inc;
        if (count == LAST_C) state_next = DONE;
      end
      DONE:  state_next = RUN;
      ERROR: state_next = WAIT_SYNC;
      RUN: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_next = LEN_LO;
      end
      default: state_next = WAIT_SYNC;
    endcase
  end

endmodule
